axi_burst_rr_arbiter: RTL and testbench

//  N-way round-robin arbiter for the AXI interconnect address/data muxes. Grant is registered and

---
 rtl/axi_burst_rr_arbiter_pkg.sv | 23 ++
 rtl/axi_burst_rr_arbiter_if.sv | 29 ++
 rtl/axi_burst_rr_arbiter_prio_pick.sv | 37 +++
 rtl/axi_burst_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_axi_burst_rr_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_rr_arbiter_pkg.sv
// Shared types and constants for the burst-holding round-robin arbiter.
// Imported by the interface, the priority picker and the arbiter top.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_LOCK = 2'd2
    } arb_state_e;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // The FSM register uses plain constants so the encoding is fixed and visible.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_burst_rr_arbiter_if.sv
// Request/handshake/grant bundle between the requesters and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface axi_burst_rr_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import arb_pkg::*;

    localparam int IW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic               hs_valid;
    logic               hs_ready;
    logic               hs_last;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_vld;

    modport master (
        output req, lock, hs_valid, hs_ready, hs_last,
        input  grant, grant_idx, grant_vld
    );

    modport slave (
        input  req, lock, hs_valid, hs_ready, hs_last,
        output grant, grant_idx, grant_vld
    );

endinterface

// File: rtl/axi_burst_rr_arbiter_prio_pick.sv
// Combinational lowest-set-bit picker: one-hot winner, its binary index and
// the mask of all bit positions strictly above the winner.
module arb_prio_pick
    import arb_pkg::*;
#(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  i_vec,
    output logic          o_any,
    output logic [W-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic [W-1:0]  o_above
);

    logic w_found;

    always_comb begin
        w_found  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        o_above  = '1;
        for (int i = 0; i < W; i++) begin
            if (i_vec[i] && !w_found) begin
                w_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = IW'(i);
                for (int j = 0; j < W; j++) begin
                    o_above[j] = (j > i);
                end
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/axi_burst_rr_arbiter.sv
// N-way round-robin / fixed-priority arbiter whose registered grant is held for a
// whole burst, with optional lock chaining bounded by MAX_LOCK bursts.
module axi_burst_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MODE     = ARB_MODE_RR,
    parameter int MAX_LOCK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_burst_rr_arbiter_if.slave     io_arb
);

    localparam int IW  = idx_width(NUM_REQ);
    localparam int LCW = idx_width(MAX_LOCK);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ptrMask;
    logic [IW-1:0]      r_grantIdx;
    logic [LCW-1:0]     r_lockCnt;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_lock;
    logic               w_eob;
    logic               w_gReq;
    logic               w_gLock;
    logic [NUM_REQ-1:0] w_pickReq;
    logic               w_mAny;
    logic [NUM_REQ-1:0] w_mOnehot;
    logic [IW-1:0]      w_mIdx;
    logic [NUM_REQ-1:0] w_mAbove;
    logic               w_aAny;
    logic [NUM_REQ-1:0] w_aOnehot;
    logic [IW-1:0]      w_aIdx;
    logic [NUM_REQ-1:0] w_aAbove;
    logic [NUM_REQ-1:0] w_winOnehot;
    logic [IW-1:0]      w_winIdx;
    logic [NUM_REQ-1:0] w_winAbove;
    logic               w_chain;
    logic               w_release;
    logic               w_load;
    logic [1:0]         w_stateNext;

    assign w_req   = io_arb.req;
    assign w_lock  = io_arb.lock;
    assign w_eob   = io_arb.hs_valid & io_arb.hs_ready & io_arb.hs_last;
    assign w_gReq  = |(r_grant & w_req);
    assign w_gLock = |(r_grant & w_lock);

    // On release in round-robin mode the outgoing owner sits out this pick, so a
    // re-asserted request only wins after an idle cycle; fixed priority never excludes.
    assign w_pickReq = (r_state == ST_IDLE || MODE == ARB_MODE_FIXED) ? w_req
                                                                       : (w_req & ~r_grant);

    arb_prio_pick #(.W(NUM_REQ), .IW(IW)) u_pickMasked (
        .i_vec    (w_pickReq & r_ptrMask),
        .o_any    (w_mAny),
        .o_onehot (w_mOnehot),
        .o_idx    (w_mIdx),
        .o_above  (w_mAbove)
    );

    arb_prio_pick #(.W(NUM_REQ), .IW(IW)) u_pickAll (
        .i_vec    (w_pickReq),
        .o_any    (w_aAny),
        .o_onehot (w_aOnehot),
        .o_idx    (w_aIdx),
        .o_above  (w_aAbove)
    );

    assign w_winOnehot = w_mAny ? w_mOnehot : w_aOnehot;
    assign w_winIdx    = w_mAny ? w_mIdx    : w_aIdx;
    assign w_winAbove  = w_mAny ? w_mAbove  : w_aAbove;

    assign w_chain = w_eob & w_gLock & w_gReq & (r_lockCnt < LOCK_LAST);

    always_comb begin
        w_release   = 1'b0;
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_aAny) w_stateNext = ST_BUSY;
            end
            ST_BUSY, ST_LOCK: begin
                w_release = w_eob & ~w_chain;
                if (r_state == ST_LOCK && !w_gReq && !io_arb.hs_valid) w_release = 1'b1;
                if (w_chain)        w_stateNext = ST_LOCK;
                else if (w_release) w_stateNext = w_aAny ? ST_BUSY : ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign w_load = (r_state == ST_IDLE) ? w_aAny : (w_release & w_aAny);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_ptrMask  <= '1;
            r_lockCnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_load) begin
                r_grant    <= w_winOnehot;
                r_grantIdx <= w_winIdx;
                r_ptrMask  <= (MODE == ARB_MODE_FIXED) ? {NUM_REQ{1'b1}} : w_winAbove;
            end else if (w_release || r_state == ST_IDLE) begin
                r_grant <= '0;
            end
            if (w_chain)        r_lockCnt <= r_lockCnt + LCW'(1);
            else if (w_release) r_lockCnt <= '0;
        end
    end

    assign io_arb.grant     = r_grant;
    assign io_arb.grant_idx = r_grantIdx;
    assign io_arb.grant_vld = |r_grant;

    // A granted requester must keep its request up until its last beat.
    a_reqHeld: assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_BUSY && !w_eob) |-> w_gReq);

    a_grantOnehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(r_grant));

endmodule

// File: tb/tb_axi_burst_rr_arbiter.sv
// Bench for axi_burst_rr_arbiter: a round-robin and a fixed-priority instance share
// one stimulus stream; a burst-level reference model feeds per-instance scoreboards.
module tb_axi_burst_rr_arbiter;
    import arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXL = 4;

    typedef struct {
        int owner;
        int last;
        int held;
        int idxOut;
    } mdl_t;

    typedef struct packed {
        logic [N-1:0] g;
        logic         v;
        logic [1:0]   i;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    mdl_t mRr, mFx;
    obs_t qRr[$];
    obs_t qFx[$];

    always #5 clk = ~clk;

    axi_burst_rr_arbiter_if #(.NUM_REQ(N)) ifRr ();
    axi_burst_rr_arbiter_if #(.NUM_REQ(N)) ifFx ();

    axi_burst_rr_arbiter #(.NUM_REQ(N), .MODE(ARB_MODE_RR), .MAX_LOCK(MAXL)) dutRr (
        .clk    (clk),
        .rst    (rst),
        .io_arb (ifRr)
    );

    axi_burst_rr_arbiter #(.NUM_REQ(N), .MODE(ARB_MODE_FIXED), .MAX_LOCK(MAXL)) dutFx (
        .clk    (clk),
        .rst    (rst),
        .io_arb (ifFx)
    );

    // Cyclic search starting at 'start': the first requester at or after it wins.
    function automatic int findFrom(input logic [N-1:0] cand, input int start);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (cand[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic mdl_t grantTo(input mdl_t s, input int who);
        mdl_t n;
        n       = s;
        n.owner = who;
        n.held  = 0;
        if (who >= 0) begin
            n.last   = who;
            n.idxOut = who;
        end
        return n;
    endfunction

    // One clock of the arbitration rules, expressed per burst and per owner.
    function automatic mdl_t step(input mdl_t s, input bit fixed, input logic rIn,
                                  input logic [N-1:0] rq, input logic [N-1:0] lk,
                                  input logic v, input logic rd, input logic l);
        mdl_t         n;
        logic [N-1:0] cand;
        int           start;
        n = s;
        if (rIn) begin
            n.owner = -1; n.last = N - 1; n.held = 0; n.idxOut = 0;
            return n;
        end
        start = fixed ? 0 : (s.last + 1) % N;
        if (s.owner < 0) begin
            if (rq != '0) n = grantTo(s, findFrom(rq, start));
            return n;
        end
        if (v && rd && l) begin
            if (lk[s.owner] && rq[s.owner] && (s.held + 1 < MAXL)) begin
                n.held = s.held + 1;
                return n;
            end
        end else if (!(s.held > 0 && !rq[s.owner] && !v)) begin
            return n;
        end
        cand = rq;
        if (!fixed) cand[s.owner] = 1'b0;
        return grantTo(s, findFrom(cand, start));
    endfunction

    function automatic obs_t observe(input mdl_t s);
        obs_t o;
        o.g = (s.owner >= 0) ? N'(1 << s.owner) : '0;
        o.v = (s.owner >= 0);
        o.i = 2'(s.idxOut);
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs; a granted owner that is not chained keeps its request up.
    task automatic applyStimulus(input logic rIn, input logic [N-1:0] rqIn, input logic [N-1:0] lk,
                                 input logic v, input logic rd, input logic l);
        logic [N-1:0] rq;
        rq = rqIn;
        @(negedge clk);
        if (!rIn && !(v && rd && l)) begin
            if (mRr.owner >= 0 && mRr.held == 0) rq[mRr.owner] = 1'b1;
            if (mFx.owner >= 0 && mFx.held == 0) rq[mFx.owner] = 1'b1;
        end
        rst = rIn;
        ifRr.req = rq; ifRr.lock = lk; ifRr.hs_valid = v; ifRr.hs_ready = rd; ifRr.hs_last = l;
        ifFx.req = rq; ifFx.lock = lk; ifFx.hs_valid = v; ifFx.hs_ready = rd; ifFx.hs_last = l;
        mRr = step(mRr, 1'b0, rIn, rq, lk, v, rd, l);
        mFx = step(mFx, 1'b1, rIn, rq, lk, v, rd, l);
        qRr.push_back(observe(mRr));
        qFx.push_back(observe(mFx));
    endtask

    task automatic burst(input logic [N-1:0] rq, input logic [N-1:0] lk, input int beats);
        for (int b = 1; b <= beats; b++) begin
            applyStimulus(1'b0, rq, lk, 1'b1, 1'b1, b == beats);
        end
    endtask

    // Monitor: compares each DUT against the next queued expectation after every edge.
    initial begin
        obs_t eR, eF;
        forever begin
            @(posedge clk);
            #1;
            if (qRr.size() > 0) begin
                eR = qRr.pop_front();
                checkOutput("rr.grant", 32'(ifRr.grant), 32'(eR.g));
                checkOutput("rr.grant_vld", 32'(ifRr.grant_vld), 32'(eR.v));
                checkOutput("rr.grant_idx", 32'(ifRr.grant_idx), 32'(eR.i));
            end
            if (qFx.size() > 0) begin
                eF = qFx.pop_front();
                checkOutput("fx.grant", 32'(ifFx.grant), 32'(eF.g));
                checkOutput("fx.grant_vld", 32'(ifFx.grant_vld), 32'(eF.v));
                checkOutput("fx.grant_idx", 32'(ifFx.grant_idx), 32'(eF.i));
            end
        end
    end

    initial begin
        logic [N-1:0] rq, lk;
        logic         v, rd, l;
        mRr = '{owner: -1, last: N - 1, held: 0, idxOut: 0};
        mFx = '{owner: -1, last: N - 1, held: 0, idxOut: 0};
        ifRr.req = '0; ifRr.lock = '0; ifRr.hs_valid = 0; ifRr.hs_ready = 0; ifRr.hs_last = 0;
        ifFx.req = '0; ifFx.lock = '0; ifFx.hs_valid = 0; ifFx.hs_ready = 0; ifFx.hs_last = 0;

        $display("[TB] reset hold and first grant");
        repeat (3) applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        burst(4'b1111, 4'b0000, 3);

        $display("[TB] round-robin rotation");
        repeat (5) burst(4'b1111, 4'b0000, 3);

        $display("[TB] lock chain");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (6) burst(4'b0101, 4'b0001, 2);

        $display("[TB] lock drop");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        burst(4'b0100, 4'b0100, 2);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        burst(4'b0100, 4'b0100, 2);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] fixed priority");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (3) burst(4'b1010, 4'b0000, 2);
        applyStimulus(1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] async reset mid-burst");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async.rr.grant", 32'(ifRr.grant), 32'h0);
        checkOutput("async.rr.grant_vld", 32'(ifRr.grant_vld), 32'h0);
        checkOutput("async.fx.grant", 32'(ifFx.grant), 32'h0);
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 800; c++) begin
            rq = N'($urandom);
            if ($urandom_range(0, 7) == 0) rq = '0;
            lk = N'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 2) == 0);
            applyStimulus(1'b0, rq, lk, v, rd, l);
        end

        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboard.drained", 32'(qRr.size() + qFx.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
